sdram_uart_dump: RTL and testbench
==================================

Name: sdram_uart_dump

Overview:
- Reader/drain side of the SDRAM FIFO read port: on a start pulse, pops a fixed number of 16-bit words from the sdram_top read FIFO (rd_en/rd_data) and serialises each word as two 8N1 UART bytes on uart_txd.
- Sits between sdram_top's user read port and the board UART TX pin. Lets the host dump SDRAM contents for test.
- Contains its own baud generator and TX shifter; no external uart_sendhs is used.

Parameters:
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
- UART_BPS, 115200, baud rate. BPS_CNT = CLK_FREQ/UART_BPS (integer division) clocks per bit.
- WORD_CNT, 16, words popped per start; 16-bit counter; 0 is legal.

Ports:
- sys_clk  input  1  single clock for all logic.
- sys_rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to begin a dump; ignored while busy=1.
- rd_en  output  1  FIFO pop strobe, one cycle per word.
- rd_data  input  16  FIFO data, valid the cycle after rd_en.
- busy  output  1  high from the cycle after start is accepted until the cycle done is asserted.
- done  output  1  one-cycle pulse after the final stop bit completes.
- uart_txd  output  1  serial out, idles high.

Behaviour:
- Reset (sync, sys_rst=1 sampled on a sys_clk edge): state=IDLE, rd_en=0, busy=0, done=0, uart_txd=1. Word counter, bit counter and baud counter clear to 0. Reset mid-frame aborts at once; the line returns high on the same edge.
- States: IDLE -> FETCH -> LATCH -> TX_LO -> TX_HI -> (FETCH or FIN) -> IDLE.
- IDLE: start=1 and WORD_CNT!=0 -> FETCH, busy<=1. start=1 and WORD_CNT==0 -> FIN; rd_en never asserts and done pulses 2 cycles after start.
- FETCH: rd_en=1 for exactly this cycle -> LATCH.
- LATCH: capture rd_data into a 16-bit holding register, word counter +1 -> TX_LO.
- TX_LO / TX_HI: send holding[7:0], then holding[15:8].
  - Each byte is 10 bits: start bit (0), 8 data bits LSB first, stop bit (1). Each bit is held for exactly BPS_CNT cycles.
  - The start bit of TX_LO appears on uart_txd the cycle after LATCH. The TX_HI start bit follows the TX_LO stop bit immediately, with no idle gap.
- After the TX_HI stop bit: if word counter==WORD_CNT -> FIN, else -> FETCH. This gives exactly 2 idle-high cycles (FETCH, LATCH) between words.
- FIN: done=1 for one cycle, busy<=0 -> IDLE. start asserted in FIN is ignored; start in the following cycle is accepted.
- Latency: start -> rd_en is 1 cycle. Start -> first start-bit edge is 3 cycles. Per word: 20*BPS_CNT + 2 cycles.
- uart_txd is a registered output, driven directly from a flop.
- FIFO empty is not checked; the block pops blindly. Upstream guarantees WORD_CNT words are available (sdram_read_valid held high).

Optional Feature:
- Macro DUMP_CHECKSUM_EN.
- Defined: an 8-bit sum (mod 256) accumulates every transmitted data byte. It clears on start acceptance. After the last word, a CSUM state sends one extra 8N1 byte containing the sum, then goes to FIN. With WORD_CNT=0, the checksum byte 0x00 is still sent.
- Undefined: no accumulator and no CSUM state; the last word goes straight to FIN.

Test Plan (CLK_FREQ=50_000_000, UART_BPS=5_000_000 -> BPS_CNT=10):
- Reset: assert sys_rst during a byte mid-transmission -> the next edge gives uart_txd=1, busy=0, rd_en=0. After release, no activity occurs without start.
- Single word: WORD_CNT=1, rd_data=0xA55A, start pulse -> rd_en high 1 cycle after start. Line decodes 0x5A then 0x55, each bit 10 cycles, 200 cycles total. done pulses once, then busy=0.
- Multi-word: WORD_CNT=3, FIFO returns 0x1234, 0xBEEF, 0x00FF -> bytes 34 12 EF BE FF 00. Exactly 3 rd_en pulses, 2-cycle high gap between words, done after the 6th stop bit.
- Start while busy: pulse start mid-dump with WORD_CNT=2 -> still only 2 rd_en pulses and a single done. A start one cycle after done launches a new dump.
- WORD_CNT=0: start -> no rd_en, uart_txd stays 1, done pulses 2 cycles after start. With DUMP_CHECKSUM_EN, a single 0x00 byte is sent first.
- DUMP_CHECKSUM_EN with WORD_CNT=2, data 0x0102, 0xFF03 -> bytes 02 01 03 FF, then checksum 0x05.

Source files
------------

// File: rtl/sdram_uart_dump.sv
// sdram_uart_dump: drains WORD_CNT 16-bit words from the SDRAM read FIFO and
// sends each one as two 8N1 UART bytes (low byte first) on uart_txd.
//
// Ports:
//   sys_clk   - single clock for all logic
//   sys_rst   - synchronous reset, active-high
//   start     - one-cycle dump request, ignored while busy
//   rd_en     - FIFO pop strobe, one cycle per word
//   rd_data   - FIFO data, valid the cycle after rd_en
//   busy      - dump in progress
//   done      - one-cycle pulse once the last stop bit has finished
//   uart_txd  - serial output, idles high, driven from a flop
//
// Optional feature macro: DUMP_CHECKSUM_EN
//   When defined, a mod-256 sum of all transmitted data bytes is sent as one
//   extra 8N1 byte after the last word (also when WORD_CNT is 0).
module sdram_uart_dump #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned UART_BPS = 115200,
    parameter int unsigned WORD_CNT = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    output logic        rd_en,
    input  logic [15:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        uart_txd
);

    localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int unsigned BAUD_W  = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam bit          HAS_WORDS = (WORD_CNT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_TX_LO,
        S_TX_HI,
`ifdef DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic                rd_en_q, rd_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                txd_q, txd_d;
    logic [15:0]         hold_q, hold_d;
    logic [15:0]         word_cnt_q, word_cnt_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                is_tx_c;
    logic                bit_tick_c;
    logic                byte_end_c;
    logic [7:0]          tx_byte_c;
    logic [9:0]          frame_c;

    // Byte currently on the wire and its 8N1 frame (bit 0 = start bit).
    always_comb begin
        tx_byte_c = hold_q[7:0];
        if (state_q == S_TX_HI) begin
            tx_byte_c = hold_q[15:8];
        end
`ifdef DUMP_CHECKSUM_EN
        if (state_q == S_CSUM) begin
            tx_byte_c = csum_q;
        end
`endif
        frame_c = {1'b1, tx_byte_c, 1'b0};
    end

    assign bit_tick_c = (baud_cnt_q == BAUD_W'(BPS_CNT - 1));

    always_comb begin
        is_tx_c = (state_q == S_TX_LO) || (state_q == S_TX_HI);
`ifdef DUMP_CHECKSUM_EN
        if (state_q == S_CSUM) begin
            is_tx_c = 1'b1;
        end
`endif
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        rd_en_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        txd_d      = txd_q;
        hold_d     = hold_q;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        byte_end_c = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        // Shared bit timer: the line only changes on a bit boundary.
        if (is_tx_c) begin
            if (bit_tick_c) begin
                baud_cnt_d = '0;
                if (bit_cnt_q == 4'd9) begin
                    byte_end_c = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    txd_d     = frame_c[bit_cnt_q + 4'd1];
                end
            end else begin
                baud_cnt_d = baud_cnt_q + BAUD_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (start) begin
                    busy_d     = 1'b1;
                    word_cnt_d = '0;
`ifdef DUMP_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    if (HAS_WORDS) begin
                        state_d = S_FETCH;
                        rd_en_d = 1'b1;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        state_d    = S_CSUM;
                        txd_d      = 1'b0;
                        bit_cnt_d  = '0;
                        baud_cnt_d = '0;
`else
                        state_d = S_FIN;
`endif
                    end
                end
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                hold_d     = rd_data;
                word_cnt_d = word_cnt_q + 16'd1;
`ifdef DUMP_CHECKSUM_EN
                csum_d     = csum_q + rd_data[7:0] + rd_data[15:8];
`endif
                txd_d      = 1'b0;
                bit_cnt_d  = '0;
                baud_cnt_d = '0;
                state_d    = S_TX_LO;
            end
            S_TX_LO: begin
                if (byte_end_c) begin
                    txd_d     = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = S_TX_HI;
                end
            end
            S_TX_HI: begin
                if (byte_end_c) begin
                    bit_cnt_d = '0;
                    if (word_cnt_q == 16'(WORD_CNT)) begin
`ifdef DUMP_CHECKSUM_EN
                        state_d = S_CSUM;
                        txd_d   = 1'b0;
`else
                        state_d = S_FIN;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        state_d = S_FETCH;
                        rd_en_d = 1'b1;
                        txd_d   = 1'b1;
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_CSUM: begin
                if (byte_end_c) begin
                    bit_cnt_d = '0;
                    txd_d     = 1'b1;
                    state_d   = S_FIN;
                end
            end
`endif
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                txd_d   = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any frame immediately.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            txd_q      <= 1'b1;
            hold_q     <= '0;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            txd_q      <= txd_d;
            hold_q     <= hold_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
`ifdef DUMP_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign rd_en    = rd_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign uart_txd = txd_q;

endmodule

// File: tb/tb_sdram_uart_dump.sv
// Testbench for sdram_uart_dump. Four instances (WORD_CNT = 1, 3, 2, 0) share
// clock, reset and a FIFO model; only one is active at a time, so the AND of
// their TX lines is decoded by a single UART monitor that checks every byte
// against a scoreboard queue filled by the stimulus.
module tb_sdram_uart_dump;

    localparam int B = 10;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [3:0]  start_v;
    logic [3:0]  rd_en_v;
    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [3:0]  txd_v;
    logic [15:0] rd_data;
    logic        line;

    assign line = &txd_v;

    always #5 clk = ~clk;

    sdram_uart_dump #(.CLK_FREQ(50_000_000), .UART_BPS(5_000_000), .WORD_CNT(1)) u_wc1 (
        .sys_clk(clk), .sys_rst(sys_rst), .start(start_v[0]), .rd_en(rd_en_v[0]),
        .rd_data(rd_data), .busy(busy_v[0]), .done(done_v[0]), .uart_txd(txd_v[0]));
    sdram_uart_dump #(.CLK_FREQ(50_000_000), .UART_BPS(5_000_000), .WORD_CNT(3)) u_wc3 (
        .sys_clk(clk), .sys_rst(sys_rst), .start(start_v[1]), .rd_en(rd_en_v[1]),
        .rd_data(rd_data), .busy(busy_v[1]), .done(done_v[1]), .uart_txd(txd_v[1]));
    sdram_uart_dump #(.CLK_FREQ(50_000_000), .UART_BPS(5_000_000), .WORD_CNT(2)) u_wc2 (
        .sys_clk(clk), .sys_rst(sys_rst), .start(start_v[2]), .rd_en(rd_en_v[2]),
        .rd_data(rd_data), .busy(busy_v[2]), .done(done_v[2]), .uart_txd(txd_v[2]));
    sdram_uart_dump #(.CLK_FREQ(50_000_000), .UART_BPS(5_000_000), .WORD_CNT(0)) u_wc0 (
        .sys_clk(clk), .sys_rst(sys_rst), .start(start_v[3]), .rd_en(rd_en_v[3]),
        .rd_data(rd_data), .busy(busy_v[3]), .done(done_v[3]), .uart_txd(txd_v[3]));

    // FIFO model and event counters, sampled on the active edge.
    logic [15:0] fifo_mem [64];
    logic [5:0]  rd_ptr = '0;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    int          low_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (|rd_en_v) begin
            rd_data <= fifo_mem[rd_ptr];
            rd_ptr  <= rd_ptr + 6'd1;
            rd_cnt  <= rd_cnt + 1;
        end
        if (|done_v) done_cnt <= done_cnt + 1;
        if (line == 1'b0) low_cnt <= low_cnt + 1;
    end

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    int          start_cyc_q[$];
    bit          mon_en;
    logic [5:0]  wr_ptr;
    logic [15:0] wv [4];
    int          cur_t, cur_n, cur_idx;
    int          rd0, d0, low0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // UART monitor: decodes each 8N1 byte cycle by cycle and pops the scoreboard.
    task automatic mon_task();
        logic [9:0] fr;
        logic       v, first;
        bit         stable;
        int         t0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && line === 1'b0) begin
                t0 = cyc;
                stable = 1'b1;
                fr = '0;
                first = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < B; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        v = line;
                        if (c == 0) first = v;
                        else if (v !== first) stable = 1'b0;
                        if (c == B / 2) fr[b] = v;
                    end
                end
                start_cyc_q.push_back(t0);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL uart_byte: unexpected byte %h at cycle %0d", fr[8:1], t0);
                end else begin
                    e = exp_q.pop_front();
                    if (fr[8:1] !== e || fr[0] !== 1'b0 || fr[9] !== 1'b1 || !stable) begin
                        n_fail++;
                        $display("FAIL uart_byte: got %h (start %b stop %b stable %0d), expected %h at cycle %0d",
                                 fr[8:1], fr[0], fr[9], stable, e, t0);
                    end
                end
            end
        end
    endtask

    function automatic int exp_start(input int j);
        if (cur_n == 0) return cur_t + 1;
        if (j < 2 * cur_n) return cur_t + 3 + (j / 2) * (20 * B + 2) + (j % 2) * 10 * B;
        return cur_t + 3 + cur_n * (20 * B + 2) - 2;
    endfunction

    // Loads the FIFO, fills the scoreboard and pulses start (caller is at a negedge).
    task automatic begin_dump(input int idx, input int n);
        logic [7:0] sum;
        sum = '0;
        start_cyc_q.delete();
        for (int k = 0; k < n; k++) begin
            fifo_mem[wr_ptr] = wv[k];
            wr_ptr = wr_ptr + 6'd1;
            exp_q.push_back(wv[k][7:0]);
            exp_q.push_back(wv[k][15:8]);
            sum = sum + wv[k][7:0] + wv[k][15:8];
        end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
        rd0 = rd_cnt;
        low0 = low_cnt;
        start_v[idx] = 1'b1;
        cur_t = cyc;
        cur_n = n;
        cur_idx = idx;
        @(negedge clk);
        start_v[idx] = 1'b0;
        d0 = done_cnt;
        if (n > 0) chk("rd_en_latency", int'(rd_en_v[idx]), 1);
        else chk("rd_en_none", int'(|rd_en_v), 0);
        chk("busy_set", int'(busy_v[idx]), 1);
    endtask

    // Waits (bounded) for done and checks counts and timing of the dump.
    task automatic finish_dump();
        bit seen;
        int nb, errs, exp_d;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            if (|done_v) seen = 1'b1;
            else @(negedge clk);
        end
        chk("done_seen", int'(seen), 1);
`ifdef DUMP_CHECKSUM_EN
        nb = 2 * cur_n + 1;
`else
        nb = 2 * cur_n;
`endif
        exp_d = (nb > 0) ? exp_start(nb - 1) + 10 * B + 1 : cur_t + 2;
        chk("done_cycle", cyc, exp_d);
        chk("busy_clear", int'(busy_v[cur_idx]), 0);
        chk("extra_done", done_cnt - d0, 0);
        chk("rd_count", rd_cnt - rd0, cur_n);
        chk("byte_count", start_cyc_q.size(), nb);
        errs = 0;
        for (int j = 0; j < nb && j < start_cyc_q.size(); j++) begin
            if (start_cyc_q[j] != exp_start(j)) errs++;
        end
        chk("byte_timing", errs, 0);
        chk("bytes_pending", exp_q.size(), 0);
        if (nb == 0) chk("line_idle", low_cnt - low0, 0);
    endtask

    initial begin
        sys_rst = 1'b1;
        start_v = '0;
        mon_en = 1'b0;
        wr_ptr = '0;
        fork
            mon_task();
        join_none

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_txd", int'(line), 1);
        chk("rst_busy", int'(|busy_v), 0);
        chk("rst_done", int'(|done_v), 0);
        chk("rst_rd_en", int'(|rd_en_v), 0);
        sys_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a byte of zeros.
        fifo_mem[wr_ptr] = 16'h0000;
        wr_ptr = wr_ptr + 6'd1;
        start_v[0] = 1'b1;
        cur_t = cyc;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int i = 0; i < 100 && cyc < cur_t + 38; i++) @(negedge clk);
        chk("midframe_low", int'(line), 0);
        sys_rst = 1'b1;
        @(negedge clk);
        chk("abort_txd", int'(line), 1);
        chk("abort_busy", int'(busy_v[0]), 0);
        chk("abort_rd_en", int'(rd_en_v[0]), 0);
        sys_rst = 1'b0;
        rd0 = rd_cnt;
        low0 = low_cnt;
        repeat (30) @(negedge clk);
        chk("idle_rd", rd_cnt - rd0, 0);
        chk("idle_line", low_cnt - low0, 0);
        chk("idle_busy", int'(|busy_v), 0);
        mon_en = 1'b1;

        // Single word.
        wv[0] = 16'hA55A;
        begin_dump(0, 1);
        finish_dump();
        repeat (5) @(negedge clk);

        // Three words.
        wv[0] = 16'h1234;
        wv[1] = 16'hBEEF;
        wv[2] = 16'h00FF;
        begin_dump(1, 3);
        finish_dump();
        repeat (5) @(negedge clk);

        // Start while busy is ignored; start in the done cycle launches a new dump.
        wv[0] = 16'h0102;
        wv[1] = 16'hFF03;
        begin_dump(2, 2);
        repeat (150) @(negedge clk);
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        finish_dump();
        wv[0] = 16'hC33C;
        wv[1] = 16'h80F1;
        begin_dump(2, 2);
        finish_dump();
        repeat (5) @(negedge clk);

        // WORD_CNT = 0.
        begin_dump(3, 0);
        finish_dump();
        repeat (20) @(negedge clk);
        chk("final_pending", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
